fc_layer: RTL and testbench

Fully-connected (dense) stage placed directly downstream of a conv/activation/pooling layer. It collects one frame of NIN pooled activations from the layer's data_out/valid_op stream into an internal buffer. It then computes NOUT neuron outputs sequentially, one MAC per cycle, with weights read from an external synchronous weight memory. Results are emitted as a serial stream with a per-neuron valid pulse and an end-of-frame pulse.

---
 rtl/cnn_pkg.sv | 36 +++
 rtl/fc_layer_mac_unit.sv | 41 ++++
 rtl/fc_layer.sv | 168 ++++++++++++++++
 tb/tb_fc_layer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared fixed-point helpers and FSM encoding for the CNN datapath blocks.
package cnn_pkg;

    // Fractional bits of the Q format shared by activations, weights and biases.
    localparam int Q_FRAC = 4;

    // Width of the intermediate value handed to sat_q.
    localparam int SAT_IW = 64;

    typedef enum logic {
        COLLECT = 1'b0,
        COMPUTE = 1'b1
    } state_e;

    // Accumulator width: full-precision product plus enough growth bits for NIN terms.
    function automatic int acc_w(input int dw, input int nin);
        return 2 * dw + $clog2(nin) + 1;
    endfunction

    // Clamp a wide signed value to the signed range of a dw-bit result.
    // The caller keeps the low dw bits of the returned value.
    function automatic logic signed [SAT_IW-1:0] sat_q(input logic signed [SAT_IW-1:0] val,
                                                       input int dw);
        logic signed [SAT_IW-1:0] hi;
        logic signed [SAT_IW-1:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (val > hi) begin
            return hi;
        end else if (val < lo) begin
            return lo;
        end
        return val;
    endfunction

endpackage

// File: rtl/fc_layer_mac_unit.sv
// Signed multiply-accumulate: acc <= 0 on clear, acc <= acc + a*b on enable.
module mac_unit #(
    parameter int DW   = 8,
    parameter int ACCW = 20
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   clr_i,
    input  logic                   en_i,
    input  logic signed [DW-1:0]   a_i,
    input  logic signed [DW-1:0]   b_i,
    output logic signed [ACCW-1:0] acc_o
);

    logic signed [2*DW-1:0] prod;
    logic signed [ACCW-1:0] acc_q;
    logic signed [ACCW-1:0] acc_d;

    // Full-precision product and next accumulator value; clear wins over enable.
    always_comb begin
        prod  = $signed({{DW{a_i[DW-1]}}, a_i}) * $signed({{DW{b_i[DW-1]}}, b_i});
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = acc_q + {{(ACCW-2*DW){prod[2*DW-1]}}, prod};
        end
    end

    // Accumulator register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/fc_layer.sv
// Dense layer: buffers NIN activations, then evaluates NOUT neurons one MAC per cycle.
//
//   state   | meaning
//   --------+-----------------------------------------------------------------
//   COLLECT | in_ready high; each in_valid sample is stored at buf[in_cnt]
//   COMPUTE | per neuron a NIN+2 cycle window: clear, NIN MACs, emit result
module fc_layer
    import cnn_pkg::*;
#(
    parameter int dataWidth = 8,
    parameter int NIN       = 4,
    parameter int NOUT      = 2,
    parameter int FRAC      = Q_FRAC,
    parameter int WAW       = (NIN * NOUT > 1) ? $clog2(NIN * NOUT) : 1
) (
    input  logic                        clk,
    input  logic                        global_rst,
    input  logic signed [dataWidth-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [WAW-1:0]              w_addr,
    input  logic signed [dataWidth-1:0] w_data,
    input  logic [NOUT*dataWidth-1:0]   bias,
    output logic signed [dataWidth-1:0] data_out,
    output logic                        valid_out,
    output logic                        done
);

    localparam int ACCW = acc_w(dataWidth, NIN);
    localparam int SW   = ACCW + 1;
    localparam int ICW  = (NIN > 1) ? $clog2(NIN) : 1;
    localparam int KW   = $clog2(NIN + 2);
    localparam int OW   = (NOUT > 1) ? $clog2(NOUT) : 1;

    localparam logic [ICW-1:0] IN_LAST = ICW'(NIN - 1);
    localparam logic [KW-1:0]  K_NIN   = KW'(NIN);
    localparam logic [KW-1:0]  K_LAST  = KW'(NIN + 1);
    localparam logic [OW-1:0]  O_LAST  = OW'(NOUT - 1);

    state_e                      state_q, state_d;
    logic [ICW-1:0]              in_cnt_q, in_cnt_d;
    logic [KW-1:0]               k_q, k_d;
    logic [OW-1:0]               o_q, o_d;
    logic [WAW-1:0]              addr_q, addr_d;
    logic signed [dataWidth-1:0] dout_q, dout_d;
    logic signed [dataWidth-1:0] act_buf_q [NIN];

    logic                        mac_clr;
    logic                        mac_en;
    logic [ICW-1:0]              rd_idx;
    logic signed [ACCW-1:0]      acc;
    logic [dataWidth-1:0]        bias_sel;
    logic signed [SW-1:0]        sum;
    logic signed [SW-1:0]        sum_sh;
    logic signed [SAT_IW-1:0]    sat_full;
    logic [SAT_IW-dataWidth-1:0] sat_unused;
    logic signed [dataWidth-1:0] result;

    // Window cycle k reads the activation that pairs with the weight addressed at k-1.
    assign rd_idx  = ICW'(k_q - KW'(1));
    assign mac_clr = (state_q == COMPUTE) && (k_q == '0);
    assign mac_en  = (state_q == COMPUTE) && (k_q != '0) && (k_q <= K_NIN);

    mac_unit #(
        .DW   (dataWidth),
        .ACCW (ACCW)
    ) u_mac (
        .clk_i (clk),
        .rst_i (global_rst),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (act_buf_q[rd_idx]),
        .b_i   (w_data),
        .acc_o (acc)
    );

    // Bias aligned to the Q point, floor shift back, then clamp to the output range.
    always_comb begin
        bias_sel   = bias[int'(o_q) * dataWidth +: dataWidth];
        sum        = {acc[ACCW-1], acc}
                   + ({{(SW-dataWidth){bias_sel[dataWidth-1]}}, bias_sel} <<< FRAC);
        sum_sh     = sum >>> FRAC;
        sat_full   = sat_q({{(SAT_IW-SW){sum_sh[SW-1]}}, sum_sh}, dataWidth);
        result     = sat_full[dataWidth-1:0];
        sat_unused = sat_full[SAT_IW-1:dataWidth];
    end

    // Next-state logic for the counters and the combinational outputs.
    always_comb begin
        state_d   = state_q;
        in_cnt_d  = in_cnt_q;
        k_d       = k_q;
        o_d       = o_q;
        addr_d    = addr_q;
        dout_d    = dout_q;
        in_ready  = 1'b0;
        valid_out = 1'b0;
        done      = 1'b0;
        w_addr    = '0;
        data_out  = dout_q;
        case (state_q)
            COLLECT: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    if (in_cnt_q == IN_LAST) begin
                        in_cnt_d = '0;
                        state_d  = COMPUTE;
                        k_d      = '0;
                        o_d      = '0;
                        addr_d   = '0;
                    end else begin
                        in_cnt_d = in_cnt_q + ICW'(1);
                    end
                end
            end
            COMPUTE: begin
                if (k_q < K_NIN) begin
                    w_addr = addr_q;
                    addr_d = addr_q + WAW'(1);
                end
                if (k_q == K_LAST) begin
                    valid_out = 1'b1;
                    data_out  = result;
                    dout_d    = result;
                    k_d       = '0;
                    if (o_q == O_LAST) begin
                        done    = 1'b1;
                        state_d = COLLECT;
                    end else begin
                        o_d = o_q + OW'(1);
                    end
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase
    end

    // Control state register; a reset anywhere abandons the current frame.
    always_ff @(posedge clk) begin
        if (global_rst) begin
            state_q  <= COLLECT;
            in_cnt_q <= '0;
            k_q      <= '0;
            o_q      <= '0;
            addr_q   <= '0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            in_cnt_q <= in_cnt_d;
            k_q      <= k_d;
            o_q      <= o_d;
            addr_q   <= addr_d;
            dout_q   <= dout_d;
        end
    end

    // Activation buffer, written only while collecting; contents need no reset.
    always_ff @(posedge clk) begin
        if ((state_q == COLLECT) && in_valid) begin
            act_buf_q[in_cnt_q] <= in_data;
        end
    end

endmodule

// File: tb/tb_fc_layer.sv
// Self-checking bench for fc_layer with a 1-cycle synchronous weight memory model.
module tb_fc_layer;

    localparam int DW   = 8;
    localparam int NIN  = 4;
    localparam int NOUT = 2;
    localparam int FRAC = 4;
    localparam int WAW  = 3;

    typedef struct {
        logic signed [DW-1:0] data;
        logic                 last;
    } exp_t;

    logic                   clk = 1'b0;
    logic                   global_rst;
    logic signed [DW-1:0]   in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic [WAW-1:0]         w_addr;
    logic signed [DW-1:0]   w_data;
    logic [NOUT*DW-1:0]     bias;
    logic signed [DW-1:0]   data_out;
    logic                   valid_out;
    logic                   done;

    logic signed [DW-1:0]   wmem   [NIN*NOUT];
    logic signed [DW-1:0]   act    [NIN];
    logic signed [DW-1:0]   bias_v [NOUT];

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   last_wr;
    exp_t exp_q[$];
    int   pulse_cyc[$];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) w_data <= wmem[w_addr];

    assign bias = {bias_v[1], bias_v[0]};

    fc_layer #(
        .dataWidth (DW),
        .NIN       (NIN),
        .NOUT      (NOUT),
        .FRAC      (FRAC)
    ) dut (
        .clk        (clk),
        .global_rst (global_rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .w_addr     (w_addr),
        .w_data     (w_data),
        .bias       (bias),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .done       (done)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic signed [DW-1:0] model(input int o);
        int acc;
        acc = 0;
        for (int i = 0; i < NIN; i++) acc += int'(act[i]) * int'(wmem[o*NIN+i]);
        acc += int'(bias_v[o]) * (1 << FRAC);
        acc = acc >>> FRAC;
        if (acc > 127) acc = 127;
        if (acc < -128) acc = -128;
        return DW'(acc);
    endfunction

    task automatic setup(input int a[NIN], input int w[NIN*NOUT], input int b0, input int b1);
        for (int i = 0; i < NIN; i++) act[i] = DW'(a[i]);
        for (int i = 0; i < NIN*NOUT; i++) wmem[i] = DW'(w[i]);
        bias_v[0] = DW'(b0);
        bias_v[1] = DW'(b1);
    endtask

    task automatic push_expected();
        exp_t e;
        for (int o = 0; o < NOUT; o++) begin
            e.data = model(o);
            e.last = (o == NOUT - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic send_frame();
        for (int i = 0; i < NIN; i++) begin
            @(negedge clk);
            in_data  = act[i];
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        last_wr  = cyc - 1;
    endtask

    // Scoreboard consumer: pops one expectation per valid_out pulse.
    task automatic collect(input int n, input int budget);
        int   seen;
        int   waited;
        exp_t e;
        seen   = 0;
        waited = 0;
        while (seen < n && waited < budget) begin
            @(negedge clk);
            waited++;
            if (valid_out === 1'b1) begin
                pulse_cyc.push_back(cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: data_out=%0d with empty scoreboard", data_out);
                end else begin
                    e = exp_q.pop_front();
                    checks++;
                    if (data_out !== e.data) begin
                        errors++;
                        $display("FAIL data_out: got %0d expected %0d", data_out, e.data);
                    end
                    checks++;
                    if (done !== e.last) begin
                        errors++;
                        $display("FAIL done_flag: got %b expected %b", done, e.last);
                    end
                end
                seen++;
            end else if (done !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL done_without_valid: done=%b valid_out=%b", done, valid_out);
            end
        end
        if (seen < n) begin
            checks++;
            errors++;
            $display("FAIL collect_timeout: got %0d pulses expected %0d", seen, n);
        end
    endtask

    task automatic test_reset();
        global_rst = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        setup('{0, 0, 0, 0}, '{0, 0, 0, 0, 0, 0, 0, 0}, 0, 0);
        repeat (3) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid_out: got %b expected 0", valid_out); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++;
        if (data_out !== 8'sd0) begin errors++; $display("FAIL reset_data_out: got %0d expected 0", data_out); end
        checks++;
        if (w_addr !== 3'd0) begin errors++; $display("FAIL reset_w_addr: got %0d expected 0", w_addr); end
        global_rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        setup('{16, 32, -16, 0}, '{16, 16, 16, 16, 16, 0, 16, 0}, 16, -8);
        push_expected();
        pulse_cyc.delete();
        send_frame();
        collect(2, 40);
        checks++;
        if (pulse_cyc.size() != 2) begin
            errors++;
            $display("FAIL basic_pulse_count: got %0d expected 2", pulse_cyc.size());
        end else begin
            checks++;
            if (pulse_cyc[0] - last_wr != NIN + 2) begin
                errors++;
                $display("FAIL basic_latency: got %0d expected %0d", pulse_cyc[0] - last_wr, NIN + 2);
            end
            checks++;
            if (pulse_cyc[1] - pulse_cyc[0] != NIN + 2) begin
                errors++;
                $display("FAIL basic_spacing: got %0d expected %0d", pulse_cyc[1] - pulse_cyc[0], NIN + 2);
            end
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL basic_back_to_collect: in_ready=%b expected 1", in_ready); end
        checks++;
        if (data_out !== -8'sd8) begin errors++; $display("FAIL basic_hold: data_out=%0d expected -8", data_out); end
    endtask

    task automatic test_sat_pos();
        setup('{127, 127, 127, 127}, '{127, 127, 127, 127, 127, 127, 127, 127}, 127, 127);
        push_expected();
        send_frame();
        collect(2, 40);
    endtask

    task automatic test_sat_neg();
        setup('{127, 127, 127, 127}, '{-128, -128, -128, -128, -128, -128, -128, -128}, -128, -128);
        push_expected();
        send_frame();
        collect(2, 40);
    endtask

    task automatic test_rounding();
        setup('{1, 0, 0, 0}, '{1, 0, 0, 0, -1, 0, 0, 0}, 0, 0);
        push_expected();
        send_frame();
        collect(2, 40);
    endtask

    task automatic test_dropped();
        logic           rdy_log [20];
        logic [WAW-1:0] wa_log  [20];
        logic           exp_rdy;
        logic [WAW-1:0] exp_wa;
        setup('{1, 2, 3, 4}, '{16, 16, 16, 16, 16, 0, 16, 0}, 16, -8);
        push_expected();
        setup('{17, 18, 19, 20}, '{16, 16, 16, 16, 16, 0, 16, 0}, 16, -8);
        push_expected();
        fork
            begin
                for (int v = 1; v <= 20; v++) begin
                    @(negedge clk);
                    in_data  = DW'(v);
                    in_valid = 1'b1;
                end
                @(negedge clk);
                in_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 20; c++) begin
                    @(negedge clk);
                    rdy_log[c] = in_ready;
                    wa_log[c]  = w_addr;
                end
            end
            collect(4, 80);
        join
        for (int c = 0; c < 20; c++) begin
            exp_rdy = (c < 4) || (c >= 16);
            exp_wa  = '0;
            if (c >= 4 && c <= 7) exp_wa = WAW'(c - 4);
            if (c >= 10 && c <= 13) exp_wa = WAW'(c - 10 + NIN);
            checks++;
            if (rdy_log[c] !== exp_rdy) begin
                errors++;
                $display("FAIL dropped_in_ready[%0d]: got %b expected %b", c, rdy_log[c], exp_rdy);
            end
            checks++;
            if (wa_log[c] !== exp_wa) begin
                errors++;
                $display("FAIL dropped_w_addr[%0d]: got %0d expected %0d", c, wa_log[c], exp_wa);
            end
        end
    endtask

    task automatic test_reset_mid();
        setup('{16, 32, -16, 0}, '{16, 16, 16, 16, 16, 0, 16, 0}, 16, -8);
        send_frame();
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (w_addr !== 3'd2) begin errors++; $display("FAIL mid_w_addr_k2: got %0d expected 2", w_addr); end
        global_rst = 1'b1;
        @(negedge clk);
        global_rst = 1'b0;
        checks++;
        if (valid_out !== 1'b0) begin errors++; $display("FAIL mid_valid_out: got %b expected 0", valid_out); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL mid_done: got %b expected 0", done); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_in_ready: got %b expected 1", in_ready); end
        checks++;
        if (w_addr !== 3'd0) begin errors++; $display("FAIL mid_w_addr: got %0d expected 0", w_addr); end
        checks++;
        if (data_out !== 8'sd0) begin errors++; $display("FAIL mid_data_out: got %0d expected 0", data_out); end
        push_expected();
        send_frame();
        collect(2, 40);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sat_pos();
        test_sat_neg();
        test_rounding();
        test_dropped();
        test_reset_mid();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
